// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: one issue register, one response buffer per port.
// Define ALU_ARB_FIXED_PRIO_EN to give port 0 fixed priority; round-robin otherwise.
module alu_arbiter #(
   parameter int TAG_W = 4,
   parameter int OP_W  = 6
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OP_W-1:0]  req0_op,
   input  logic [31:0]      req0_rs1,
   input  logic [31:0]      req0_rs2,
   input  logic [31:0]      req0_imm,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OP_W-1:0]  req1_op,
   input  logic [31:0]      req1_rs1,
   input  logic [31:0]      req1_rs2,
   input  logic [31:0]      req1_imm,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [OP_W-1:0]  alu_op,
   output logic [31:0]      alu_rs1,
   output logic [31:0]      alu_rs2,
   output logic [31:0]      alu_imm,
   input  logic [31:0]      alu_result,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_data,
   output logic [TAG_W-1:0] rsp0_tag,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_data,
   output logic [TAG_W-1:0] rsp1_tag
);

   logic                       iss_v;
   logic                       iss_src;
   logic [OP_W-1:0]            iss_op;
   logic [31:0]                iss_rs1;
   logic [31:0]                iss_rs2;
   logic [31:0]                iss_imm;
   logic [TAG_W-1:0]           iss_tag;

   logic [1:0]                 rsp_v;
   logic [1:0][31:0]           rsp_d;
   logic [1:0][TAG_W-1:0]      rsp_t;
   logic [1:0]                 rsp_rdy;
   logic [1:0]                 fill;

   logic                       iss_adv;
   logic                       can_acc;
   logic                       gnt_v;
   logic                       gnt;
   logic                       acc;
   logic                       prio;

   assign rsp_rdy = {rsp1_ready, rsp0_ready};

   // The issue register retires only into a free (or simultaneously drained) buffer.
   assign iss_adv = iss_v && (!rsp_v[iss_src] || rsp_rdy[iss_src]);
   assign can_acc = !iss_v || iss_adv;
   assign fill    = {iss_adv && iss_src, iss_adv && !iss_src};

   always_comb begin
      gnt = req1_valid;
      if (req0_valid && req1_valid)
         gnt = prio;
   end

   assign gnt_v = req0_valid || req1_valid;
   assign acc   = can_acc && gnt_v;

   // Readies are masked during reset because an empty issue register would otherwise admit.
   assign req0_ready = acc && !gnt && !rstn;
   assign req1_ready = acc &&  gnt && !rstn;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign prio = 1'b0;
`else
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)
         prio <= 1'b0;
      else if (acc)
         prio <= !gnt;
   end
`endif

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         iss_v   <= 1'b0;
         iss_src <= 1'b0;
         iss_op  <= '0;
         iss_rs1 <= '0;
         iss_rs2 <= '0;
         iss_imm <= '0;
         iss_tag <= '0;
      end else if (acc) begin
         iss_v   <= 1'b1;
         iss_src <= gnt;
         iss_op  <= gnt ? req1_op  : req0_op;
         iss_rs1 <= gnt ? req1_rs1 : req0_rs1;
         iss_rs2 <= gnt ? req1_rs2 : req0_rs2;
         iss_imm <= gnt ? req1_imm : req0_imm;
         iss_tag <= gnt ? req1_tag : req0_tag;
      end else if (iss_adv) begin
         iss_v   <= 1'b0;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_rsp
      always_ff @(posedge clk or posedge rstn) begin
         if (rstn) begin
            rsp_v[g] <= 1'b0;
            rsp_d[g] <= '0;
            rsp_t[g] <= '0;
         end else if (fill[g]) begin
            rsp_v[g] <= 1'b1;
            rsp_d[g] <= alu_result;
            rsp_t[g] <= iss_tag;
         end else if (rsp_rdy[g]) begin
            rsp_v[g] <= 1'b0;
         end
      end
   end

   assign alu_op  = iss_v ? iss_op  : '0;
   assign alu_rs1 = iss_v ? iss_rs1 : '0;
   assign alu_rs2 = iss_v ? iss_rs2 : '0;
   assign alu_imm = iss_v ? iss_imm : '0;

   assign rsp0_valid = rsp_v[0];
   assign rsp0_data  = rsp_d[0];
   assign rsp0_tag   = rsp_t[0];
   assign rsp1_valid = rsp_v[1];
   assign rsp1_data  = rsp_d[1];
   assign rsp1_tag   = rsp_t[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small reference ALU on the shared port.
// Expectations for the both-valid case follow ALU_ARB_FIXED_PRIO_EN when it is defined.
module tb_alu_arbiter;

   localparam int TAG_W = 4;
   localparam int OP_W  = 6;
   localparam logic [OP_W-1:0] OP_ADD = 6'd1;
   localparam logic [OP_W-1:0] OP_SUB = 6'd2;
   localparam logic [OP_W-1:0] OP_XOR = 6'd3;
   localparam logic [OP_W-1:0] OP_AND = 6'd4;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0;
   logic req0_ready, req1_ready;
   logic [OP_W-1:0] req0_op = '0, req1_op = '0;
   logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req0_imm = '0;
   logic [31:0] req1_rs1 = '0, req1_rs2 = '0, req1_imm = '0;
   logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
   logic [OP_W-1:0] alu_op;
   logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_result;
   logic rsp0_valid, rsp1_valid;
   logic rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] rsp0_data, rsp1_data;
   logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

   int n_chk = 0;
   int n_pass = 0;

   alu_arbiter #(.TAG_W(TAG_W), .OP_W(OP_W)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_imm(req0_imm), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_imm(req1_imm), .req1_tag(req1_tag),
      .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
      .alu_result(alu_result),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_op)
         OP_ADD:  alu_result = alu_rs1 + alu_rs2;
         OP_SUB:  alu_result = alu_rs1 - alu_rs2;
         OP_XOR:  alu_result = alu_rs1 ^ alu_rs2;
         OP_AND:  alu_result = alu_rs1 & alu_rs2;
         default: alu_result = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [OP_W-1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
      req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b; req0_tag = t;
   endtask

   task automatic set_req1(input logic v, input logic [OP_W-1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] t);
      req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b; req1_tag = t;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_g;
      // Reset state, with a request pending to prove readies are masked.
      set_req0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd0);
      step(); step();
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("rst_alu_op", {26'd0, alu_op}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      set_req0(1'b0, '0, '0, '0, '0);
      rstn = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      step();

      // Single ADD on port 0, two-cycle latency.
      set_req0(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3);
      #1;
      chk("add_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("add_req1_ready", {31'd0, req1_ready}, 32'd0);
      step();
      set_req0(1'b0, '0, '0, '0, '0);
      chk("add_alu_op", {26'd0, alu_op}, {26'd0, OP_ADD});
      chk("add_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
      step();
      chk("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("add_rsp0_data", rsp0_data, 32'd12);
      chk("add_rsp0_tag", {28'd0, rsp0_tag}, 32'd3);
      step();
      chk("add_rsp0_drained", {31'd0, rsp0_valid}, 32'd0);

      // Both ports valid continuously; port 0 was served last, so port 1 leads.
      set_req0(1'b1, OP_ADD, 32'd1, 32'd2, 4'd1);
      set_req1(1'b1, OP_SUB, 32'd10, 32'd3, 4'd2);
      for (int i = 0; i < 6; i++) begin
         #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_g = 1'b0;
`else
         exp_g = (i % 2 == 0);
`endif
         chk("rr_req0_ready", {31'd0, req0_ready}, {31'd0, !exp_g});
         chk("rr_req1_ready", {31'd0, req1_ready}, {31'd0, exp_g});
         if (i >= 2) begin
            if (exp_g) begin
               chk("rr_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
               chk("rr_rsp1_data", rsp1_data, 32'd7);
               chk("rr_rsp1_tag", {28'd0, rsp1_tag}, 32'd2);
            end else begin
               chk("rr_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
               chk("rr_rsp0_data", rsp0_data, 32'd3);
               chk("rr_rsp0_tag", {28'd0, rsp0_tag}, 32'd1);
            end
         end
         step();
      end
      set_req0(1'b0, '0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0, '0);
      step(); step(); step();
      chk("rr_idle_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

      // Head-of-line stall behind a full rsp0.
      rsp0_ready = 1'b0;
      set_req0(1'b1, OP_SUB, 32'd9, 32'd4, 4'd5);
      #1;
      chk("hol_sub_ready", {31'd0, req0_ready}, 32'd1);
      step();
      set_req0(1'b1, OP_XOR, 32'hF0, 32'h0F, 4'd6);
      #1;
      chk("hol_xor_ready", {31'd0, req0_ready}, 32'd1);
      step();
      set_req0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd8);
      set_req1(1'b1, OP_ADD, 32'd2, 32'd2, 4'd9);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("hol_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
         chk("hol_rsp0_data", rsp0_data, 32'd5);
         chk("hol_rsp0_tag", {28'd0, rsp0_tag}, 32'd5);
         chk("hol_alu_op", {26'd0, alu_op}, {26'd0, OP_XOR});
         chk("hol_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         step();
      end
      set_req0(1'b0, '0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0, '0);
      rsp0_ready = 1'b1;
      step();
      chk("hol_refill_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("hol_refill_data", rsp0_data, 32'hFF);
      chk("hol_refill_tag", {28'd0, rsp0_tag}, 32'd6);
      chk("hol_issue_empty", {26'd0, alu_op}, 32'd0);

      // Drain and fill of rsp0 on the same edge.
      rsp0_ready = 1'b0;
      set_req0(1'b1, OP_AND, 32'hF0, 32'h3C, 4'd7);
      #1;
      chk("df_req0_ready", {31'd0, req0_ready}, 32'd1);
      step();
      set_req0(1'b0, '0, '0, '0, '0);
      chk("df_hold_data", rsp0_data, 32'hFF);
      chk("df_alu_op", {26'd0, alu_op}, {26'd0, OP_AND});
      rsp0_ready = 1'b1;
      step();
      chk("df_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("df_data", rsp0_data, 32'h30);
      chk("df_tag", {28'd0, rsp0_tag}, 32'd7);
      step();
      chk("df_drained", {31'd0, rsp0_valid}, 32'd0);

      // Reset mid-operation: rsp1 full, issue holding a port-0 op, prio pointing at port 1.
      rsp1_ready = 1'b0;
      set_req1(1'b1, OP_ADD, 32'd3, 32'd4, 4'd2);
      step();
      set_req1(1'b0, '0, '0, '0, '0);
      set_req0(1'b1, OP_SUB, 32'd8, 32'd1, 4'd4);
      step();
      set_req0(1'b0, '0, '0, '0, '0);
      chk("mid_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("mid_alu_op", {26'd0, alu_op}, {26'd0, OP_SUB});
      #2;
      rstn = 1'b1;
      #1;
      chk("arst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("arst_alu_op", {26'd0, alu_op}, 32'd0);
      step();
      rstn = 1'b0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_valids", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end
      set_req0(1'b1, OP_ADD, 32'd1, 32'd1, 4'd1);
      set_req1(1'b1, OP_ADD, 32'd2, 32'd2, 4'd2);
      #1;
      chk("post_rst_grant0", {31'd0, req0_ready}, 32'd1);
      chk("post_rst_grant1", {31'd0, req1_ready}, 32'd0);
      step();
      set_req0(1'b0, '0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0, '0);
      step();
      chk("post_rst_rsp0", rsp0_data, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, request/response tag width.
REQ-002 SHALL have parameter OP_W, default 6, ALU opcode width; code 0 = NOP, ALU result 0.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn  in  1  reset; asynchronous, active-high (1 = reset).
REQ-005 SHALL have ports reqN_valid in 1, reqN_ready out 1, reqN_op in OP_W, reqN_rs1 in 32, reqN_rs2 in 32, reqN_imm in 32, reqN_tag in TAG_W, for N = 0,1.
REQ-006 SHALL have ports alu_op out OP_W, alu_rs1 out 32, alu_rs2 out 32, alu_imm out 32, alu_result in 32; these connect to the shared combinational ALU.
REQ-007 SHALL have ports rspN_valid out 1, rspN_ready in 1, rspN_data out 32, rspN_tag out TAG_W, for N = 0,1.

Function
REQ-008 SHALL transfer a request/response only on a cycle where valid and ready are both 1.
REQ-009 SHALL hold one issue register: iss_v, iss_src, op, operands, tag.
REQ-010 SHALL drive alu_* from the issue register when iss_v=1; otherwise alu_op=0 and operands 0.
REQ-011 SHALL advance the issue register (iss_adv) when iss_v=1 and rsp[iss_src] is empty or drained the same cycle.
REQ-012 SHALL, on iss_adv, load alu_result and tag into rsp[iss_src] buffer and set its valid.
REQ-013 SHALL accept a new request when iss_v=0 or iss_adv=1 (no bubble on back-to-back issue).
REQ-014 SHALL grant: only one port valid -> that port; both valid -> port given by pointer prio.
REQ-015 SHALL set prio to the non-granted port after each accepted request; prio unchanged otherwise.
REQ-016 SHALL assert reqN_ready only for the granted port; both readies never 1 simultaneously.
REQ-017 SHALL give latency of 2 cycles: accepted at edge T, rspN_valid=1 after edge T+1.
REQ-018 SHALL hold rspN_valid, data, tag stable until rspN_ready=1.
REQ-019 SHALL, on simultaneous drain and fill of one response buffer, present the new entry with valid staying 1.
REQ-020 SHALL block both ports while the issue register stalls on a full response buffer (head-of-line, by design).
REQ-021 SHALL never drop or duplicate a response; responses per port in acceptance order.

Reset
REQ-022 SHALL, while rstn=1, clear iss_v, rsp0_valid, rsp1_valid, prio=0, all data/tag registers to 0.
REQ-023 SHALL, while rstn=1, drive req0_ready=req1_ready=0 and alu_op=0.
REQ-024 SHALL discard in-flight operations on reset mid-operation; no response after release.

Configuration
REQ-025 SHALL, with ALU_ARB_FIXED_PRIO_EN defined, always grant port 0 when both valid; prio register removed.
REQ-026 SHALL, without ALU_ARB_FIXED_PRIO_EN, use round-robin per REQ-014/015.

Verification
REQ-027 Port0 ADD rs1=5 rs2=7 tag=3, rsp0_ready=1 -> rsp0_valid 2 cycles later, data=12, tag=3.
REQ-028 Both ports valid continuously, responses always ready -> grants 0,1,0,1,...; one acceptance per cycle.
REQ-029 rsp0_ready=0, port0 sends SUB 9-4 then XOR -> rsp0=5 held, XOR stalled in issue, req0/req1_ready=0 until rsp0_ready=1.
REQ-030 rsp0 full, rsp0_ready=1 same cycle as advancing AND 0xF0&0x3C -> rsp0_valid stays 1, data=0x30 next cycle.
REQ-031 rstn=1 pulse while iss_v=1 -> all valids 0 asynchronously; no response after release; first grant goes to port 0.
REQ-032 ALU_ARB_FIXED_PRIO_EN defined, both valid 4 cycles -> port0 granted all 4, req1_ready=0.
